// File: rtl/radar_frame_scheduler_pkg.sv
// Shared types for the radar frame scheduler.
//   state_t      : scheduler FSM encoding (IDLE=0 .. GAP=4)
//   frame_desc_t : packed 48-bit frame descriptor, as stored in the queue
//   desc_valid() : descriptor sanity check applied when a descriptor is popped
package radar_timing_pkg;

    localparam int PERIOD_W  = 16;
    localparam int WIDTH_W   = 16;
    localparam int NUM_PRI_W = 8;
    localparam int REPEAT_W  = 8;
    localparam int DESC_W    = PERIOD_W + WIDTH_W + NUM_PRI_W + REPEAT_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_PRI  = 3'd2,
        ST_EOF  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0]  pri_period;
        logic [WIDTH_W-1:0]   pulse_width;
        logic [NUM_PRI_W-1:0] num_pri;
        logic [REPEAT_W-1:0]  rep;
    } frame_desc_t;

    // A pulse must be at least one clock and leave some low time in every PRI.
    function automatic logic desc_valid(frame_desc_t d);
        return (d.pulse_width != '0) && (d.pulse_width < d.pri_period) &&
               (d.num_pri != '0);
    endfunction

endpackage

// File: rtl/radar_frame_scheduler_if.sv
// Host descriptor push bus.
//   cfg_valid/cfg_ready : push handshake (push when both high)
//   cfg_*               : descriptor fields carried with cfg_valid
// master = host side, slave = scheduler side.
interface radar_frame_scheduler_if;
    import radar_timing_pkg::*;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [PERIOD_W-1:0]  cfg_pri_period;
    logic [WIDTH_W-1:0]   cfg_pulse_width;
    logic [NUM_PRI_W-1:0] cfg_num_pri;
    logic [REPEAT_W-1:0]  cfg_repeat;

    modport master (
        output cfg_valid, cfg_pri_period, cfg_pulse_width, cfg_num_pri, cfg_repeat,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pri_period, cfg_pulse_width, cfg_num_pri, cfg_repeat,
        output cfg_ready
    );

endinterface

// File: rtl/radar_frame_scheduler_cfg_fifo.sv
// radar_cfg_fifo: synchronous DEPTH x WIDTH first-word-fall-through FIFO.
//   clk, reset : clock, synchronous active-high reset (flushes pointers/level)
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty); dout always shows the head
//   level      : number of stored words, full = (level == DEPTH)
module radar_cfg_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 48,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset; level gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/radar_frame_scheduler.sv
// radar_frame_scheduler: plays queued frame descriptors as SOF / PRI / EOF
// strobes, followed by a fixed inter-frame gap.
//   clk, reset        : clock, synchronous active-high reset
//   run               : level, allows new frames / repeats to start
//   abort             : pulse, kills the current frame (ignored in IDLE)
//   cfg               : descriptor push bus (slave side)
//   start_of_frame, pulse_repetition_interval, end_of_frame : timing strobes
//   busy              : FSM not in IDLE
//   queue_level       : descriptors waiting in the queue
//   frame_count       : frames that reached the end of EOF (wraps)
//   cfg_err / aborted : one-cycle status pulses
module radar_frame_scheduler
    import radar_timing_pkg::*;
#(
    parameter  int SOF_CYCLES = 40,
    parameter  int EOF_CYCLES = 120,
    parameter  int GAP_CYCLES = 16,
    parameter  int DEPTH      = 4,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    abort,
    radar_frame_scheduler_if.slave  cfg,
    output logic                    start_of_frame,
    output logic                    pulse_repetition_interval,
    output logic                    end_of_frame,
    output logic                    busy,
    output logic [LW-1:0]           queue_level,
    output logic [15:0]             frame_count,
    output logic                    cfg_err,
    output logic                    aborted
);

    frame_desc_t          head;
    logic [DESC_W-1:0]    fifo_dout;
    logic                 fifo_full;
    logic                 pop;

    state_t               state, state_n;
    logic [31:0]          cnt, cnt_n;           // SOF/EOF/GAP dwell counter
    logic [PERIOD_W-1:0]  phase, phase_n;
    logic [NUM_PRI_W-1:0] pri_idx, pri_idx_n;
    logic [REPEAT_W-1:0]  rep_left, rep_left_n;
    logic [PERIOD_W-1:0]  act_period, act_period_n;
    logic [WIDTH_W-1:0]   act_width, act_width_n;
    logic [NUM_PRI_W-1:0] act_num, act_num_n;
    logic [15:0]          frame_count_n;
    logic                 cfg_err_n;
    logic                 aborted_n;

    radar_cfg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cfg.cfg_valid),
        .din   ({cfg.cfg_pri_period, cfg.cfg_pulse_width, cfg.cfg_num_pri, cfg.cfg_repeat}),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (queue_level),
        .full  (fifo_full)
    );

    assign head          = frame_desc_t'(fifo_dout);
    assign cfg.cfg_ready = !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            phase       <= '0;
            pri_idx     <= '0;
            rep_left    <= '0;
            act_period  <= '0;
            act_width   <= '0;
            act_num     <= '0;
            frame_count <= '0;
            cfg_err     <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            phase       <= phase_n;
            pri_idx     <= pri_idx_n;
            rep_left    <= rep_left_n;
            act_period  <= act_period_n;
            act_width   <= act_width_n;
            act_num     <= act_num_n;
            frame_count <= frame_count_n;
            cfg_err     <= cfg_err_n;
            aborted     <= aborted_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        phase_n       = phase;
        pri_idx_n     = pri_idx;
        rep_left_n    = rep_left;
        act_period_n  = act_period;
        act_width_n   = act_width;
        act_num_n     = act_num;
        frame_count_n = frame_count;
        cfg_err_n     = 1'b0;
        aborted_n     = 1'b0;
        pop           = 1'b0;

        if (abort && state != ST_IDLE) begin
            // Remaining repeats die with the frame; queue is left untouched.
            state_n   = ST_IDLE;
            aborted_n = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run && queue_level != '0) begin
                        pop = 1'b1;
                        if (desc_valid(head)) begin
                            act_period_n = head.pri_period;
                            act_width_n  = head.pulse_width;
                            act_num_n    = head.num_pri;
                            rep_left_n   = head.rep;
                            state_n      = ST_SOF;
                            cnt_n        = '0;
                            phase_n      = '0;
                        end else begin
                            cfg_err_n = 1'b1;
                        end
                    end
                end
                ST_SOF: begin
                    if (cnt == 32'(SOF_CYCLES - 1)) begin
                        state_n   = ST_PRI;
                        phase_n   = '0;
                        pri_idx_n = '0;
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                ST_PRI: begin
                    if (phase == act_period - 16'd1) begin
                        phase_n = '0;
                        if (pri_idx == act_num - 8'd1) begin
                            state_n = ST_EOF;
                            cnt_n   = '0;
                        end else begin
                            pri_idx_n = pri_idx + 8'd1;
                        end
                    end else begin
                        phase_n = phase + 16'd1;
                    end
                end
                ST_EOF: begin
                    if (cnt == 32'(EOF_CYCLES - 1)) begin
                        state_n       = ST_GAP;
                        cnt_n         = '0;
                        frame_count_n = frame_count + 16'd1;
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 32'(GAP_CYCLES - 1)) begin
                        cnt_n = '0;
                        // run low at the end of the gap drops the remaining repeats.
                        if (rep_left != '0 && run) begin
                            rep_left_n = rep_left - 8'd1;
                            state_n    = ST_SOF;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign start_of_frame            = (state == ST_SOF);
    assign end_of_frame              = (state == ST_EOF);
    assign pulse_repetition_interval = (state == ST_PRI) && (phase < act_width);
    assign busy                      = (state != ST_IDLE);

endmodule

// File: tb/tb_radar_frame_scheduler.sv
module tb_radar_frame_scheduler;
    import radar_timing_pkg::*;

    localparam int SOF   = 40;
    localparam int EOFC  = 120;
    localparam int GAP   = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, run, abort;
    logic          start_of_frame, pulse_repetition_interval, end_of_frame, busy;
    logic [LW-1:0] queue_level;
    logic [15:0]   frame_count;
    logic          cfg_err, aborted;

    always #5 clk = ~clk;

    radar_frame_scheduler_if cfg_bus ();

    radar_frame_scheduler #(
        .SOF_CYCLES (SOF),
        .EOF_CYCLES (EOFC),
        .GAP_CYCLES (GAP),
        .DEPTH      (DEPTH)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .run                       (run),
        .abort                     (abort),
        .cfg                       (cfg_bus),
        .start_of_frame            (start_of_frame),
        .pulse_repetition_interval (pulse_repetition_interval),
        .end_of_frame              (end_of_frame),
        .busy                      (busy),
        .queue_level               (queue_level),
        .frame_count               (frame_count),
        .cfg_err                   (cfg_err),
        .aborted                   (aborted)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time since the frame's first SOF cycle plus a queue.
    frame_desc_t m_q[$];
    bit          m_busy;
    int          m_t;
    frame_desc_t m_d;
    int          m_rep;
    int          m_fc;
    bit          m_err, m_abt;

    int pri_hi_seen;
    int err_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int frame_body(frame_desc_t d);
        return SOF + int'(d.num_pri) * int'(d.pri_period);
    endfunction

    // Advance the model by one clock using the inputs applied before the edge.
    task automatic model_step();
        bit          do_push;
        frame_desc_t pd, h;
        int          body;
        do_push = cfg_bus.cfg_valid && (m_q.size() < DEPTH);
        pd = {cfg_bus.cfg_pri_period, cfg_bus.cfg_pulse_width,
              cfg_bus.cfg_num_pri, cfg_bus.cfg_repeat};
        m_err = 0;
        m_abt = 0;
        if (reset) begin
            m_q.delete();
            m_busy = 0;
            m_fc   = 0;
            m_t    = 0;
            m_rep  = 0;
        end else begin
            if (m_busy && abort) begin
                m_busy = 0;
                m_abt  = 1;
            end else if (m_busy) begin
                body = frame_body(m_d);
                m_t++;
                if (m_t == body + EOFC) m_fc = (m_fc + 1) % 65536;
                if (m_t == body + EOFC + GAP) begin
                    if (m_rep > 0 && run) begin
                        m_rep--;
                        m_t = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
            end else if (run && m_q.size() > 0) begin
                h = m_q.pop_front();
                if (h.pulse_width >= 1 && h.pulse_width < h.pri_period && h.num_pri >= 1) begin
                    m_busy = 1;
                    m_t    = 0;
                    m_d    = h;
                    m_rep  = int'(h.rep);
                end else begin
                    m_err = 1;
                end
            end
            if (do_push) m_q.push_back(pd);
        end
    endtask

    task automatic check_outputs();
        int body, sof_e, pri_e, eof_e;
        sof_e = 0; pri_e = 0; eof_e = 0;
        if (m_busy) begin
            body = frame_body(m_d);
            if (m_t < SOF) sof_e = 1;
            else if (m_t < body)
                pri_e = (((m_t - SOF) % int'(m_d.pri_period)) < int'(m_d.pulse_width)) ? 1 : 0;
            else if (m_t < body + EOFC) eof_e = 1;
        end
        chk("sof",         start_of_frame, sof_e);
        chk("pri",         pulse_repetition_interval, pri_e);
        chk("eof",         end_of_frame, eof_e);
        chk("busy",        busy, m_busy);
        chk("queue_level", queue_level, m_q.size());
        chk("cfg_ready",   cfg_bus.cfg_ready, (m_q.size() < DEPTH) ? 1 : 0);
        chk("frame_count", frame_count, m_fc);
        chk("cfg_err",     cfg_err, m_err);
        chk("aborted",     aborted, m_abt);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        if (pulse_repetition_interval) pri_hi_seen++;
        if (cfg_err) err_seen++;
    endtask

    task automatic push(input int p, input int w, input int n, input int r);
        cfg_bus.cfg_valid       = 1'b1;
        cfg_bus.cfg_pri_period  = 16'(p);
        cfg_bus.cfg_pulse_width = 16'(w);
        cfg_bus.cfg_num_pri     = 8'(n);
        cfg_bus.cfg_repeat      = 8'(r);
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((m_busy || (run && m_q.size() > 0)) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_t(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (!(m_busy && m_t == target) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_reach"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int period, width, num, rep;
        bit valid;
        int pri_hi;
        int frames;
    } vec_t;

    vec_t vt[7];

    initial begin
        int fc0;
        vt[0] = '{10, 3, 2, 0, 1,  6, 1};
        vt[1] = '{10, 3, 2, 2, 1, 18, 3};
        vt[2] = '{ 5, 5, 1, 0, 0,  0, 0};
        vt[3] = '{ 5, 0, 1, 0, 0,  0, 0};
        vt[4] = '{ 8, 2, 0, 0, 0,  0, 0};
        vt[5] = '{ 2, 1, 3, 1, 1,  6, 2};
        vt[6] = '{ 7, 6, 1, 0, 1,  6, 1};

        reset = 1'b1; run = 1'b0; abort = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_pri_period = '0; cfg_bus.cfg_pulse_width = '0;
        cfg_bus.cfg_num_pri = '0;    cfg_bus.cfg_repeat = '0;
        m_busy = 0; m_t = 0; m_fc = 0; m_rep = 0; m_err = 0; m_abt = 0;
        m_d = '0;
        pri_hi_seen = 0; err_seen = 0;

        do_reset();
        chk("reset_ready", cfg_bus.cfg_ready, 1);
        chk("reset_fc", frame_count, 0);

        // Table-driven single descriptors.
        foreach (vt[i]) begin
            fc0 = frame_count;
            run = 1'b0;
            push(vt[i].period, vt[i].width, vt[i].num, vt[i].rep);
            chk($sformatf("tbl%0d_level", i), queue_level, 1);
            pri_hi_seen = 0; err_seen = 0;
            run = 1'b1;
            wait_idle($sformatf("tbl%0d", i), 4000);
            run = 1'b0;
            chk($sformatf("tbl%0d_frames", i), int'(frame_count) - fc0, vt[i].frames);
            chk($sformatf("tbl%0d_pri_hi", i), pri_hi_seen, vt[i].pri_hi);
            chk($sformatf("tbl%0d_err", i), err_seen, vt[i].valid ? 0 : 1);
            chk($sformatf("tbl%0d_level0", i), queue_level, 0);
        end

        // Fill: fifth push refused.
        run = 1'b0;
        for (int i = 0; i < 5; i++) push(10, 3, 2, 0);
        chk("fill_level", queue_level, 4);
        chk("fill_ready", cfg_bus.cfg_ready, 0);

        // Abort inside the second PRI; next queued frame launches.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", aborted, 0);
        fc0 = frame_count;
        run = 1'b1;
        wait_t("abort", SOF + 10 + 1, 200);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_pri", pulse_repetition_interval, 0);
        chk("abort_fc", int'(frame_count) - fc0, 0);
        chk("abort_level", queue_level, 3);
        tick();
        chk("abort_pulse_end", aborted, 0);
        chk("relaunch_busy", busy, 1);
        chk("relaunch_level", queue_level, 2);
        run = 1'b0;
        wait_idle("abort_drain", 1000);
        do_reset();

        // Abort coincident with a launch from IDLE is ignored.
        push(10, 3, 2, 0);
        run = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_launch_busy", busy, 1);
        chk("abort_launch_pulse", aborted, 0);
        run = 1'b0;
        wait_idle("abort_launch", 1000);

        // Drop run mid-PRI of a repeat-3 frame: only one frame completes.
        fc0 = frame_count;
        push(10, 3, 2, 3);
        run = 1'b1;
        wait_t("rundrop", SOF + 5, 200);
        run = 1'b0;
        wait_idle("rundrop", 1000);
        chk("rundrop_frames", int'(frame_count) - fc0, 1);
        chk("rundrop_busy", busy, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            cfg_bus.cfg_valid       = ($urandom_range(0, 15) == 0);
            cfg_bus.cfg_pri_period  = 16'($urandom_range(0, 6));
            cfg_bus.cfg_pulse_width = 16'($urandom_range(0, 6));
            cfg_bus.cfg_num_pri     = 8'($urandom_range(0, 3));
            cfg_bus.cfg_repeat      = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 299) == 0) run = ~run;
            abort = ($urandom_range(0, 499) == 0);
            tick();
        end
        cfg_bus.cfg_valid = 1'b0;
        abort = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
